// File: rtl/mips_loader_pkg.sv
// rtl/mips_loader_pkg.sv - shared types and constants for the MIPS instruction-memory loader
package mips_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        CHECK,
        RUN
    } state_e;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
    localparam int         LANE_W         = 2;

endpackage

// File: rtl/mips_word_packer.sv
// rtl/mips_word_packer.sv - big-endian byte-to-word shift register with word-complete strobe
module mips_word_packer
    import mips_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [23:0]       shift_q, shift_d;
    logic [LANE_W-1:0] lane_q,  lane_d;

    always_comb begin
        shift_d = shift_q;
        lane_d  = lane_q;
        if (clear_i) begin
            shift_d = '0;
            lane_d  = '0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[15:0], byte_i};
            lane_d  = lane_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_q <= '0;
            lane_q  <= '0;
        end else begin
            shift_q <= shift_d;
            lane_q  <= lane_d;
        end
    end

    // The completed word includes the byte arriving this cycle, so the strobe is combinational.
    assign word_o      = {shift_q, byte_i};
    assign word_done_o = byte_valid_i && !clear_i && (lane_q == '1);

endmodule

// File: rtl/mips_imem_loader.sv
// rtl/mips_imem_loader.sv - byte-serial, checksum-verified program loader for the MIPS instruction memory
module mips_imem_loader
    import mips_loader_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_reset_o,
    output logic              load_done_o,
    output logic              load_error_o
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_e            state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [15:0]       remain_q, remain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        chk_q, chk_d;

    logic              rx_ready_q;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;

    logic              accept;
    logic              is_header;
    logic              pack_clear;
    logic              pack_valid;
    logic [31:0]       pack_word;
    logic              pack_done;
    logic [15:0]       count_full;

    assign accept     = rx_valid_i && rx_ready_q;
    assign is_header  = accept && (rx_data_i == HEADER);
    assign pack_clear = is_header && ((state_q == IDLE) || (state_q == RUN));
    assign pack_valid = accept && (state_q == DATA);
    assign count_full = {cnt_hi_q, rx_data_i};

    mips_word_packer u_packer (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (pack_clear),
        .byte_valid_i (pack_valid),
        .byte_i       (rx_data_i),
        .word_o       (pack_word),
        .word_done_o  (pack_done)
    );

    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        remain_d     = remain_q;
        addr_d       = addr_q;
        chk_d        = chk_q;
        load_error_d = load_error_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            IDLE, RUN: begin
                if (is_header) begin
                    state_d      = CNT_HI;
                    addr_d       = '0;
                    chk_d        = '0;
                    load_error_d = 1'b0;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    cnt_hi_d = rx_data_i;
                    state_d  = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    remain_d = count_full;
                    // An image larger than the memory would wrap and overwrite itself.
                    if ({1'b0, count_full} > DEPTH) begin
                        load_error_d = 1'b1;
                        state_d      = IDLE;
                    end else if (count_full == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    chk_d = chk_q ^ rx_data_i;
                    if (pack_done) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = addr_q;
                        imem_wdata_d = pack_word;
                        addr_d       = addr_q + ADDR_W'(1);
                        remain_d     = remain_q - 16'd1;
                        if (remain_q == 16'd1) begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (rx_data_i == chk_q) begin
                        state_d = RUN;
                    end else begin
                        load_error_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Processor status follows the next state so it changes one cycle after the deciding byte.
        cpu_reset_d = (state_d != RUN);
        load_done_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_hi_q     <= '0;
            remain_q     <= '0;
            addr_q       <= '0;
            chk_q        <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            remain_q     <= remain_d;
            addr_q       <= addr_d;
            chk_q        <= chk_d;
            rx_ready_q   <= 1'b1;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign rx_ready_o   = rx_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign load_done_o  = load_done_q;
    assign load_error_o = load_error_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// tb/tb_mips_imem_loader.sv - self-checking bench for mips_imem_loader
module tb_mips_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] words[$];

    always #5 clk = ~clk;

    mips_imem_loader dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .rx_ready_o   (rx_ready),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .cpu_reset_o  (cpu_reset),
        .load_done_o  (load_done),
        .load_error_o (load_error)
    );

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat (int'($urandom_range(1, 5))) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic end_stream();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Reference: COUNT > 256 is rejected with no writes; otherwise every word is written in
    // order from address 0 and the image runs only if CHK equals the XOR of payload bytes.
    task automatic run_frame(input int cnt, input logic [7:0] badmask, input bit gaps, input string tag);
        logic [15:0] c;
        logic [31:0] w;
        logic [7:0]  x;
        bit          oversize;
        int          n;
        c        = cnt[15:0];
        oversize = (cnt > 256);
        x        = 8'h00;
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'hA5, gaps);
        @(negedge clk);
        rx_valid = 1'b0;
        check({tag, " hdr_cpu_reset"}, cpu_reset, 1'b1);
        check({tag, " hdr_load_done"}, load_done, 1'b0);
        check({tag, " hdr_load_error"}, load_error, 1'b0);
        send_byte(c[15:8], gaps);
        send_byte(c[7:0], gaps);
        if (!oversize) begin
            for (int i = 0; i < cnt; i++) begin
                w = words[i];
                for (int b = 3; b >= 0; b--) begin
                    send_byte(w[8*b +: 8], gaps);
                    x = x ^ w[8*b +: 8];
                end
            end
            send_byte(x ^ badmask, gaps);
        end
        end_stream();
        if (oversize || badmask != 8'h00) begin
            check({tag, " load_error"}, load_error, 1'b1);
            check({tag, " load_done"}, load_done, 1'b0);
            check({tag, " cpu_reset"}, cpu_reset, 1'b1);
        end else begin
            check({tag, " load_error"}, load_error, 1'b0);
            check({tag, " load_done"}, load_done, 1'b1);
            check({tag, " cpu_reset"}, cpu_reset, 1'b0);
        end
        repeat (2) @(negedge clk);
        n = oversize ? 0 : cnt;
        check({tag, " nwrites"}, wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check({tag, " waddr"}, wr_addr_q[i], i[7:0]);
            check({tag, " wdata"}, wr_data_q[i], words[i]);
        end
    endtask

    initial begin
        int          cnt;
        logic [7:0]  mask;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst rx_ready", rx_ready, 1'b0);
        check("rst imem_we", imem_we, 1'b0);
        check("rst imem_addr", imem_addr, 8'h00);
        check("rst imem_wdata", imem_wdata, 32'h0);
        check("rst cpu_reset", cpu_reset, 1'b1);
        check("rst load_done", load_done, 1'b0);
        check("rst load_error", load_error, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst rx_ready", rx_ready, 1'b1);

        words = '{32'h20080005, 32'h20090003, 32'h01095020};
        run_frame(3, 8'h00, 1'b0, "nominal");

        run_frame(3, 8'h01, 1'b0, "badchk");

        wr_addr_q.delete();
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h13, 1'b0);
        end_stream();
        @(negedge clk);
        check("noise load_error", load_error, 1'b1);
        check("noise cpu_reset", cpu_reset, 1'b1);
        check("noise nwrites", wr_addr_q.size(), 0);
        words = '{32'h20080005, 32'h20090003, 32'h01095020};
        run_frame(3, 8'h00, 1'b1, "gaps");

        run_frame(257, 8'h00, 1'b0, "oversize");
        fill_words(5);
        run_frame(5, 8'h00, 1'b0, "after_oversize");

        words = '{32'h20080005, 32'h20090003, 32'h01095020};
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int b = 0; b < 6; b++) begin
            send_byte(8'hFF - 8'(b), 1'b0);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("midrst rx_ready", rx_ready, 1'b0);
        check("midrst imem_we", imem_we, 1'b0);
        check("midrst imem_addr", imem_addr, 8'h00);
        check("midrst imem_wdata", imem_wdata, 32'h0);
        check("midrst cpu_reset", cpu_reset, 1'b1);
        check("midrst load_done", load_done, 1'b0);
        check("midrst load_error", load_error, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst nwrites", wr_addr_q.size(), 1);
        run_frame(3, 8'h00, 1'b0, "resend");

        words = '{32'h00000000};
        run_frame(1, 8'h00, 1'b0, "reload");
        run_frame(0, 8'h00, 1'b0, "count0");

        fill_words(256);
        run_frame(256, 8'h00, 1'b0, "fulldepth");

        for (int it = 0; it < 12; it++) begin
            cnt = int'($urandom_range(0, 12));
            if ($urandom_range(0, 5) == 0) cnt = int'($urandom_range(257, 65535));
            mask = 8'h00;
            if ($urandom_range(0, 2) == 0) mask = 8'(1 << $urandom_range(0, 7));
            fill_words(cnt > 256 ? 0 : cnt);
            run_frame(cnt, mask, 1'($urandom_range(0, 1)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
